// File: rtl/sensor_request_conditioner.sv
// Vehicle-loop front end: synchronises, debounces and latches per-road requests
// for the traffic light controller, with arrival counts and stuck-loop detection.

module src_channel #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned STUCK_CYCLES    = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        raw_i,
    input  logic [1:0]  light_i,
    output logic        req_o,
    output logic        stuck_o,
    output logic [15:0] count_o
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned HI_W = $clog2(STUCK_CYCLES + 1);
    localparam logic [1:0]  GREEN = 2'b11;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   stable_q, stable_d;
    logic                   stable_dly_q, stable_dly_d;
    logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
    logic [HI_W-1:0]        hi_cnt_q, hi_cnt_d;
    logic                   stuck_q, stuck_d;
    logic                   req_q, req_d;
    logic [15:0]            count_q, count_d;
    logic                   arrival_c;

    // Next-state for synchroniser, debouncer, arrival, request and stuck tracking
    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], raw_i};
        stable_d     = stable_q;
        db_cnt_d     = '0;
        stable_dly_d = stable_q;
        count_d      = count_q;
        hi_cnt_d     = '0;
        req_d        = req_q;

        if (sync_q[SYNC_STAGES-1] != stable_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync_q[SYNC_STAGES-1];
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end

        arrival_c = stable_q & ~stable_dly_q;
        if (arrival_c && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end

        if (stable_q) begin
            hi_cnt_d = (hi_cnt_q == HI_W'(STUCK_CYCLES)) ? hi_cnt_q : hi_cnt_q + HI_W'(1);
        end
        stuck_d = (hi_cnt_d == HI_W'(STUCK_CYCLES));

        // Own GREEN serves the road; a stuck loop must never hold a request
        if (arrival_c) begin
            req_d = 1'b1;
        end
        if ((light_i == GREEN) || stuck_d) begin
            req_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q       <= '0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            db_cnt_q     <= '0;
            hi_cnt_q     <= '0;
            stuck_q      <= 1'b0;
            req_q        <= 1'b0;
            count_q      <= '0;
        end else begin
            sync_q       <= sync_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            db_cnt_q     <= db_cnt_d;
            hi_cnt_q     <= hi_cnt_d;
            stuck_q      <= stuck_d;
            req_q        <= req_d;
            count_q      <= count_d;
        end
    end

    assign req_o   = req_q;
    assign stuck_o = stuck_q;
    assign count_o = count_q;

endmodule

module sensor_request_conditioner #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned STUCK_CYCLES    = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        raw_main_sensor,
    input  logic        raw_side_sensor,
    input  logic [1:0]  main_road_light,
    input  logic [1:0]  side_road_light,
    output logic        main_road_sensor,
    output logic        side_road_sensor,
    output logic        main_stuck,
    output logic        side_stuck,
    output logic [15:0] main_count,
    output logic [15:0] side_count
);

    // Two fully independent channels, each served by its own road's light
    src_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_main (
        .clk     (clk),
        .reset   (reset),
        .raw_i   (raw_main_sensor),
        .light_i (main_road_light),
        .req_o   (main_road_sensor),
        .stuck_o (main_stuck),
        .count_o (main_count)
    );

    src_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_side (
        .clk     (clk),
        .reset   (reset),
        .raw_i   (raw_side_sensor),
        .light_i (side_road_light),
        .req_o   (side_road_sensor),
        .stuck_o (side_stuck),
        .count_o (side_count)
    );

endmodule

// File: tb/tb_sensor_request_conditioner.sv
// Directed self-checking bench for sensor_request_conditioner with default parameters.

module tb_sensor_request_conditioner;

    logic        clk = 1'b0;
    logic        reset;
    logic        raw_main_sensor, raw_side_sensor;
    logic [1:0]  main_road_light, side_road_light;
    logic        main_road_sensor, side_road_sensor;
    logic        main_stuck, side_stuck;
    logic [15:0] main_count, side_count;

    int n_checks = 0;
    int n_errors = 0;

    sensor_request_conditioner dut (
        .clk              (clk),
        .reset            (reset),
        .raw_main_sensor  (raw_main_sensor),
        .raw_side_sensor  (raw_side_sensor),
        .main_road_light  (main_road_light),
        .side_road_light  (side_road_light),
        .main_road_sensor (main_road_sensor),
        .side_road_sensor (side_road_sensor),
        .main_stuck       (main_stuck),
        .side_stuck       (side_stuck),
        .main_count       (main_count),
        .side_count       (side_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges; outputs are sampled 1 ns after the last edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        tick(n);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] all_outs();
        return {10'd0, main_road_sensor, side_road_sensor, main_stuck, side_stuck,
                main_count[7:0], side_count[7:0]} | {16'd0, main_count | side_count};
    endfunction

    initial begin
        reset = 1'b1;
        raw_main_sensor = 1'b1;
        raw_side_sensor = 1'b0;
        main_road_light = 2'b00;
        side_road_light = 2'b00;

        // Reset held 2 cycles with main raw high: everything stays 0
        tick(1);
        chk("reset_c1", all_outs(), 32'd0);
        tick(1);
        chk("reset_c2", all_outs(), 32'd0);
        reset = 1'b0;
        raw_main_sensor = 1'b0;
        tick(1);
        chk("reset_release", all_outs(), 32'd0);

        // 3-cycle glitch on side is rejected
        raw_side_sensor = 1'b1;
        tick(3);
        raw_side_sensor = 1'b0;
        tick(10);
        chk("glitch_req", 32'(side_road_sensor), 32'd0);
        chk("glitch_cnt", 32'(side_count), 32'd0);

        // Clean side arrival, held through YELLOW, cleared by GREEN
        do_reset(2);
        main_road_light = 2'b11;
        side_road_light = 2'b00;
        raw_side_sensor = 1'b1;
        tick(6);
        chk("clean_req_e6", 32'(side_road_sensor), 32'd0);
        chk("clean_cnt_e6", 32'(side_count), 32'd0);
        tick(1);
        chk("clean_req_e7", 32'(side_road_sensor), 32'd1);
        chk("clean_cnt_e7", 32'(side_count), 32'd1);
        chk("clean_main_idle", 32'(main_road_sensor), 32'd0);
        side_road_light = 2'b01;
        tick(3);
        chk("clean_yellow_hold", 32'(side_road_sensor), 32'd1);
        side_road_light = 2'b11;
        tick(1);
        chk("clean_green_clr", 32'(side_road_sensor), 32'd0);
        raw_side_sensor = 1'b0;
        side_road_light = 2'b00;

        // Main arrival during main GREEN: counted, no request
        do_reset(2);
        main_road_light = 2'b11;
        raw_main_sensor = 1'b1;
        tick(6);
        raw_main_sensor = 1'b0;
        tick(1);
        chk("green_arr_cnt", 32'(main_count), 32'd1);
        chk("green_arr_req", 32'(main_road_sensor), 32'd0);
        tick(10);
        main_road_light = 2'b00;
        tick(3);
        chk("green_arr_req_late", 32'(main_road_sensor), 32'd0);
        chk("green_arr_cnt_late", 32'(main_count), 32'd1);

        // Stuck main loop
        do_reset(2);
        main_road_light = 2'b00;
        raw_main_sensor = 1'b1;
        tick(7);
        chk("stuck_req_e7", 32'(main_road_sensor), 32'd1);
        tick(1005 - 7);
        chk("stuck_flag_e1005", 32'(main_stuck), 32'd0);
        chk("stuck_req_e1005", 32'(main_road_sensor), 32'd1);
        tick(1);
        chk("stuck_flag_e1006", 32'(main_stuck), 32'd1);
        chk("stuck_req_e1006", 32'(main_road_sensor), 32'd0);
        tick(4);
        chk("stuck_flag_e1010", 32'(main_stuck), 32'd1);
        chk("stuck_req_e1010", 32'(main_road_sensor), 32'd0);
        raw_main_sensor = 1'b0;
        tick(6);
        chk("stuck_hold_e1016", 32'(main_stuck), 32'd1);
        tick(1);
        chk("stuck_clr_e1017", 32'(main_stuck), 32'd0);
        chk("stuck_req_after", 32'(main_road_sensor), 32'd0);
        chk("stuck_cnt", 32'(main_count), 32'd1);

        // Reset on cycle 5 of a debounce restarts the full latency
        do_reset(2);
        raw_main_sensor = 1'b1;
        tick(4);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(6);
        chk("mid_rst_req_e6", 32'(main_road_sensor), 32'd0);
        tick(1);
        chk("mid_rst_req_e7", 32'(main_road_sensor), 32'd1);
        chk("mid_rst_cnt_e7", 32'(main_count), 32'd1);
        raw_main_sensor = 1'b0;

        // Simultaneous arrivals, independent clears, repeat arrival while pending
        do_reset(2);
        raw_main_sensor = 1'b1;
        raw_side_sensor = 1'b1;
        tick(7);
        chk("both_main_req", 32'(main_road_sensor), 32'd1);
        chk("both_side_req", 32'(side_road_sensor), 32'd1);
        chk("both_counts", {main_count, side_count}, {16'd1, 16'd1});
        main_road_light = 2'b11;
        tick(1);
        chk("indep_main_clr", 32'(main_road_sensor), 32'd0);
        chk("indep_side_hold", 32'(side_road_sensor), 32'd1);
        raw_side_sensor = 1'b0;
        tick(8);
        raw_side_sensor = 1'b1;
        tick(7);
        chk("repeat_side_cnt", 32'(side_count), 32'd2);
        chk("repeat_side_req", 32'(side_road_sensor), 32'd1);
        chk("no_stuck", {30'd0, main_stuck, side_stuck}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sensor_request_conditioner.md
# sensor_request_conditioner

Upstream front end for the traffic light controller. It takes the raw, asynchronous vehicle-loop sensors for the main and side roads, synchronises and debounces them, and turns each vehicle arrival into a latched request. Each request is held on `main_road_sensor` / `side_road_sensor` until the controller serves that road with GREEN. It also counts arrivals per road and flags loops that are stuck high.

## Interface
- `SYNC_STAGES`, 2 — synchroniser depth per raw input (≥2).
- `DEBOUNCE_CYCLES`, 4 — consecutive synchronised samples that must differ from the debounced level before it changes (≥1).
- `STUCK_CYCLES`, 1000 — consecutive cycles of debounced-high that declare a loop stuck.
- `clk  in  1` — single clock, rising edge.
- `reset  in  1` — synchronous, active-high reset.
- `raw_main_sensor  in  1` — asynchronous main-road loop detector.
- `raw_side_sensor  in  1` — asynchronous side-road loop detector.
- `main_road_light  in  2` — controller main-road output; 00 RED, 01 YELLOW, 11 GREEN.
- `side_road_light  in  2` — controller side-road output; same encoding.
- `main_road_sensor  out  1` — latched main-road request to the controller.
- `side_road_sensor  out  1` — latched side-road request to the controller.
- `main_stuck  out  1` — main loop stuck-high fault.
- `side_stuck  out  1` — side loop stuck-high fault.
- `main_count  out  16` — saturating main-road arrival count.
- `side_count  out  16` — saturating side-road arrival count.

## Operation
Two identical channels, main and side. Each channel uses its own road's light input.

- **Synchroniser:** `SYNC_STAGES` flops, all cleared by reset.
- **Debouncer:** registered level `stable` plus a counter.
  - Counter clears whenever the synchroniser output equals `stable`.
  - Otherwise it increments. When the `DEBOUNCE_CYCLES`-th consecutive differing sample is seen, `stable` takes the new value and the counter clears in the same edge.
  - Shorter excursions are discarded.
- **Arrival:** a registered 0→1 transition of `stable`.
  - Increments the count, saturating at 65535 (no wrap).
  - Sets the request latch.
- **Request clear:** the request latch clears on any edge where the channel's own light is 11 (GREEN).
  - If set and clear occur together, clear wins: an arrival during own GREEN yields no request, but the count still increments.
  - YELLOW and RED never clear a request.
  - Repeated arrivals while a request is pending keep it set; only the count changes.
- **Stuck detection:** a high-time counter increments while `stable` = 1 and clears when `stable` = 0. It saturates at `STUCK_CYCLES`.
  - When it reaches `STUCK_CYCLES`, `stuck` is set and the request latch is forced to 0.
  - While `stuck` = 1, the request stays 0.
  - `stuck` clears on the edge after `stable` falls to 0. Normal operation resumes from that point.
- **Independence:** channels share no state. Simultaneous arrivals on both roads are handled independently, and both requests may be high together.
- **Reset:** synchronous, active-high, and it wins over every other event. It clears the synchronisers, `stable`, all counters, request latches, stuck flags and arrival counts.
  - A reset asserted mid-debounce discards the partial count.
  - After reset the raw input must again satisfy the full latency.

## Timing
- All outputs are registered. Reset value of every output is 0.
- **Rise latency:** raw input steady from before edge 1 → synchroniser output valid at edge `SYNC_STAGES` → `stable` rises at edge `SYNC_STAGES`+`DEBOUNCE_CYCLES` → request and count update at edge `SYNC_STAGES`+`DEBOUNCE_CYCLES`+1. With defaults this is edge 7.
- **Fall latency:** identical, `SYNC_STAGES`+`DEBOUNCE_CYCLES` edges for `stable` to fall.
- **Request clear:** request falls on the first edge that samples own light = 11. It is visible one cycle after GREEN appears at the input.
- **Stuck flag:** `stuck` and the forced request clear assert on the edge where the high-time counter reaches `STUCK_CYCLES`, i.e. `STUCK_CYCLES` edges after `stable` rose.
- **No combinational path** from inputs to outputs.

## Test plan
- **Reset:** assert reset 2 cycles with `raw_main_sensor` = 1 → every output 0 throughout and on the first edge after release.
- **Glitch rejection:** after reset, pulse `raw_side_sensor` high for 3 cycles with defaults → `side_road_sensor` stays 0, `side_count` stays 0.
- **Clean arrival:** hold `raw_side_sensor` = 1 from edge 1 with main light 11 and side light 00 → `side_road_sensor` = 1 and `side_count` = 1 at edge 7. Request stays 1 through side YELLOW. Drive side light 11 → request 0 on the next edge.
- **Arrival during own GREEN:** `raw_main_sensor` pulse of 6 cycles while main light = 11 → `main_count` +1, `main_road_sensor` remains 0.
- **Stuck loop:** hold `raw_main_sensor` = 1 for 1010 cycles with main light 00 → request rises at edge 7. At edge 1006 (stable rose at 6, +1000) `main_stuck` = 1 and `main_road_sensor` = 0. Release the input → `main_stuck` = 0 one edge after `stable` falls.
- **Reset mid-debounce:** raw high for 5 cycles, reset on cycle 5, raw held high → request first rises 7 edges after reset deasserts.
